ysyx_25020032_fetch_ctrl: RTL and testbench

Multi-cycle instruction fetch controller for the NPC core. It sequences instruction memory requests, latches the returned instruction and its PC, and presents them to the decode/execute stage over a valid/ready handshake. It also drives the immediate extender's select (`imm_src`, `shamt`) from the latched opcode, so the rest of the datapath sees a stable instruction, PC and immediate configuration for the whole issue window.

---
 rtl/ysyx_25020032_fetch_ctrl_pkg.sv | 23 ++
 rtl/ysyx_25020032_fetch_ctrl_if.sv | 32 +++
 rtl/ysyx_25020032_imm_decode.sv | 33 +++
 rtl/ysyx_25020032_fetch_ctrl.sv | 108 ++++++++++
 tb/tb_ysyx_25020032_fetch_ctrl.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_25020032_fetch_ctrl_pkg.sv
// Shared definitions for the fetch controller: immediate-type select codes and RV32I opcodes.
package ysyx_25020032_fetch_ctrl_pkg;

    typedef enum logic [2:0] {
        I_TYPE = 3'd0,
        U_TYPE = 3'd1,
        J_TYPE = 3'd2,
        S_TYPE = 3'd3,
        B_TYPE = 3'd4
    } instr_type_e;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

endpackage

// File: rtl/ysyx_25020032_fetch_ctrl_if.sv
// Fetch controller bus: instruction-memory request/response and decode-side issue handshake.
interface ysyx_25020032_fetch_ctrl_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic [2:0]  imm_src;
    logic        shamt;
    logic        illegal;
    logic [31:0] next_pc;
    logic        fault;

    modport master (
        output imem_req_valid, imem_addr, id_valid, id_pc, id_instr,
               imm_src, shamt, illegal, fault,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err,
               id_ready, next_pc
    );

    modport slave (
        input  imem_req_valid, imem_addr, id_valid, id_pc, id_instr,
               imm_src, shamt, illegal, fault,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err,
               id_ready, next_pc
    );
endinterface

// File: rtl/ysyx_25020032_imm_decode.sv
// Combinational opcode decode: immediate-type select, shift-amount form and illegal-opcode flag.
module ysyx_25020032_imm_decode
    import ysyx_25020032_fetch_ctrl_pkg::*;
(
    input  logic [31:0]  instr,
    output instr_type_e  imm_src,
    output logic         shamt,
    output logic         illegal
);
    logic [6:0] opcode;
    logic [2:0] funct3;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];

    always_comb begin
        imm_src = I_TYPE;
        illegal = 1'b0;
        case (opcode)
            OP_LUI, OP_AUIPC:                      imm_src = U_TYPE;
            OP_JAL:                                imm_src = J_TYPE;
            OP_JALR, OP_LOAD, OP_IMM, OP_SYSTEM:   imm_src = I_TYPE;
            OP_STORE:                              imm_src = S_TYPE;
            OP_BRANCH:                             imm_src = B_TYPE;
            // R-type carries no immediate; the select value is unused.
            OP_REG:                                imm_src = I_TYPE;
            default:                               illegal = 1'b1;
        endcase
    end

    assign shamt = (opcode == OP_IMM) && ((funct3 == 3'b001) || (funct3 == 3'b101));

endmodule

// File: rtl/ysyx_25020032_fetch_ctrl.sv
// Multi-cycle fetch FSM (REQ -> WAIT -> ISSUE) holding PC and instruction for decode.
// Optional fault detection/HALT state is enabled by defining YSYX_25020032_FETCH_FAULT_EN.
module ysyx_25020032_fetch_ctrl
    import ysyx_25020032_fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    ysyx_25020032_fetch_ctrl_if.master    bus
);
    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_ISSUE
`ifdef YSYX_25020032_FETCH_FAULT_EN
        , S_HALT
`endif
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        fault_q, fault_d;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        fault_d = fault_q;
        case (state_q)
            S_REQ: if (bus.imem_req_ready) state_d = S_WAIT;
            S_WAIT: begin
                if (bus.imem_rsp_valid) begin
`ifdef YSYX_25020032_FETCH_FAULT_EN
                    if (bus.imem_rsp_err) begin
                        state_d = S_HALT;
                        fault_d = 1'b1;
                    end else begin
                        instr_d = bus.imem_rsp_data;
                        state_d = S_ISSUE;
                    end
`else
                    instr_d = bus.imem_rsp_data;
                    state_d = S_ISSUE;
`endif
                end
            end
            S_ISSUE: begin
                if (bus.id_ready) begin
`ifdef YSYX_25020032_FETCH_FAULT_EN
                    if (bus.next_pc[1:0] != 2'b00) begin
                        state_d = S_HALT;
                        fault_d = 1'b1;
                    end else begin
                        pc_d    = bus.next_pc;
                        state_d = S_REQ;
                    end
`else
                    pc_d    = {bus.next_pc[31:2], 2'b00};
                    state_d = S_REQ;
`endif
                end
            end
            default: state_d = state_q;  // HALT is left only through reset
        endcase
`ifndef YSYX_25020032_FETCH_FAULT_EN
        fault_d = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            instr_q <= 32'h0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            fault_q <= fault_d;
        end
    end

    instr_type_e imm_src_w;
    logic        shamt_w;
    logic        illegal_w;

    ysyx_25020032_imm_decode u_imm_decode (
        .instr   (instr_q),
        .imm_src (imm_src_w),
        .shamt   (shamt_w),
        .illegal (illegal_w)
    );

    // REQ is the reset state, so gate the request with rst_n to keep it low during reset.
    assign bus.imem_req_valid = rst_n && (state_q == S_REQ);
    assign bus.imem_addr      = pc_q;
    assign bus.id_valid       = (state_q == S_ISSUE);
    assign bus.id_pc          = pc_q;
    assign bus.id_instr       = instr_q;
    assign bus.imm_src        = imm_src_w;
    assign bus.shamt          = shamt_w;
    assign bus.illegal        = illegal_w;
    assign bus.fault          = fault_q;

endmodule

// File: tb/tb_ysyx_25020032_fetch_ctrl.sv
// Directed bench for the fetch controller; fault checks run when YSYX_25020032_FETCH_FAULT_EN is defined.
module tb_ysyx_25020032_fetch_ctrl;
    import ysyx_25020032_fetch_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    ysyx_25020032_fetch_ctrl_if bus ();

    ysyx_25020032_fetch_ctrl #(.RESET_PC(32'h8000_0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // From REQ at a negedge: accept request, return data next cycle, end in ISSUE.
    task automatic fetch(input logic [31:0] data);
        bus.imem_req_ready = 1'b1;
        tick();
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = data;
        tick();
        bus.imem_rsp_valid = 1'b0;
    endtask

    task automatic issue(input logic [31:0] npc);
        bus.id_ready = 1'b1;
        bus.next_pc  = npc;
        tick();
        bus.id_ready = 1'b0;
    endtask

    logic [31:0] held;

    initial begin
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        bus.imem_rsp_err   = 1'b0;
        bus.id_ready       = 1'b0;
        bus.next_pc        = 32'h0;

        // reset state
        tick();
        tick();
        chk("rst_req_valid", bus.imem_req_valid, 1'b0);
        chk("rst_id_valid",  bus.id_valid, 1'b0);
        chk("rst_fault",     bus.fault, 1'b0);
        chk("rst_id_instr",  bus.id_instr, 32'h0);
        chk("rst_addr",      bus.imem_addr, 32'h8000_0000);

        // first fetch: addi
        rst_n = 1'b1;
        #1;
        chk("first_req_valid", bus.imem_req_valid, 1'b1);
        chk("first_addr",      bus.imem_addr, 32'h8000_0000);
        fetch(32'h0050_0093);
        chk("addi_id_valid", bus.id_valid, 1'b1);
        chk("addi_instr",    bus.id_instr, 32'h0050_0093);
        chk("addi_pc",       bus.id_pc, 32'h8000_0000);
        chk("addi_imm_src",  bus.imm_src, I_TYPE);
        chk("addi_shamt",    bus.shamt, 1'b0);
        chk("addi_illegal",  bus.illegal, 1'b0);
        chk("addi_no_req",   bus.imem_req_valid, 1'b0);

        // decode stall
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_id_valid", bus.id_valid, 1'b1);
            chk("stall_instr",    bus.id_instr, 32'h0050_0093);
        end
        issue(32'h8000_0010);
        chk("redir_req_valid", bus.imem_req_valid, 1'b1);
        chk("redir_addr",      bus.imem_addr, 32'h8000_0010);
        chk("redir_id_valid",  bus.id_valid, 1'b0);

        // memory backpressure, with a stray response that must be ignored
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'hDEAD_BEEF;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("bp_req_valid", bus.imem_req_valid, 1'b1);
            chk("bp_addr",      bus.imem_addr, 32'h8000_0010);
            chk("bp_id_valid",  bus.id_valid, 1'b0);
        end
        bus.imem_rsp_valid = 1'b0;
        chk("bp_instr_kept", bus.id_instr, 32'h0050_0093);

        fetch(32'h0030_1013);
        chk("slli_pc",      bus.id_pc, 32'h8000_0010);
        chk("slli_shamt",   bus.shamt, 1'b1);
        chk("slli_imm_src", bus.imm_src, I_TYPE);
        issue(32'h8000_0014);

        fetch(32'hFFFF_F0B7);
        chk("lui_imm_src", bus.imm_src, U_TYPE);
        chk("lui_illegal", bus.illegal, 1'b0);
        chk("lui_shamt",   bus.shamt, 1'b0);
        issue(32'h8000_0018);

        fetch(32'h0000_007F);
        chk("ill_illegal", bus.illegal, 1'b1);
        chk("ill_imm_src", bus.imm_src, I_TYPE);
        held = 32'h0000_007F;

`ifdef YSYX_25020032_FETCH_FAULT_EN
        issue(32'h8000_0002);
        chk("misal_fault", bus.fault, 1'b1);
        for (int i = 0; i < 3; i++) begin
            bus.imem_req_ready = 1'b1;
            tick();
            chk("misal_halt_req",   bus.imem_req_valid, 1'b0);
            chk("misal_halt_idv",   bus.id_valid, 1'b0);
            chk("misal_fault_hold", bus.fault, 1'b1);
        end
        bus.imem_req_ready = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_halt_fault", bus.fault, 1'b0);
        tick();
        tick();
        tick();
        tick();
        fetch(32'h0000_0000);
        issue(32'h8000_001C);
`else
        issue(32'h8000_001E);
        chk("misal_forced_addr", bus.imem_addr, 32'h8000_001C);
        chk("misal_no_fault",    bus.fault, 1'b0);
`endif

        // reset while in WAIT; stale response after release must be dropped
        bus.imem_req_ready = 1'b1;
        tick();
        bus.imem_req_ready = 1'b0;
        chk("wait_no_req", bus.imem_req_valid, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midrst_req_valid", bus.imem_req_valid, 1'b0);
        chk("midrst_addr",      bus.imem_addr, 32'h8000_0000);
        tick();
        rst_n = 1'b1;
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'h0000_0013;
        tick();
        bus.imem_rsp_valid = 1'b0;
        chk("stale_req_valid", bus.imem_req_valid, 1'b1);
        chk("stale_id_valid",  bus.id_valid, 1'b0);
        chk("stale_addr",      bus.imem_addr, 32'h8000_0000);
        chk("stale_instr",     bus.id_instr, 32'h0);

        fetch(32'h0000_0517);
        chk("auipc_imm_src", bus.imm_src, U_TYPE);
        chk("auipc_pc",      bus.id_pc, 32'h8000_0000);
        held = 32'h0000_0517;

`ifdef YSYX_25020032_FETCH_FAULT_EN
        issue(32'h8000_0004);
        bus.imem_req_ready = 1'b1;
        tick();
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_err   = 1'b1;
        bus.imem_rsp_data  = 32'hDEAD_BEEF;
        tick();
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_err   = 1'b0;
        chk("err_fault",    bus.fault, 1'b1);
        chk("err_instr",    bus.id_instr, held);
        chk("err_id_valid", bus.id_valid, 1'b0);
        for (int i = 0; i < 3; i++) begin
            bus.imem_req_ready = 1'b1;
            tick();
            chk("err_halt_req",   bus.imem_req_valid, 1'b0);
            chk("err_fault_hold", bus.fault, 1'b1);
        end
        bus.imem_req_ready = 1'b0;
`else
        issue(32'h8000_0004);
        bus.imem_req_ready = 1'b1;
        tick();
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_err   = 1'b1;
        bus.imem_rsp_data  = 32'h0000_0063;
        tick();
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_err   = 1'b0;
        chk("err_ignored_idv",  bus.id_valid, 1'b1);
        chk("err_ignored_fault", bus.fault, 1'b0);
        chk("beq_imm_src",      bus.imm_src, B_TYPE);
        chk("beq_pc",           bus.id_pc, 32'h8000_0004);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
